color_interpolator_arbiter: RTL and testbench

Shares one 2-stage color interpolator pipeline between two requesters, for example the fog unit and the texture-environment unit.
- Accepts interpolation jobs on two valid/ready slave ports and grants them round-robin.
- Drives the shared interpolator's operand and clock-enable inputs.
- Tracks each in-flight job's owner with a tag pipeline and returns each result on that owner's master port.
- Stalls the shared pipeline via clock-enable when the destination applies backpressure.

---
 rtl/color_interpolator_arbiter.sv | 120 ++++++++++++
 tb/tb_color_interpolator_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/color_interpolator_arbiter.sv
// Round-robin arbiter sharing one pipelined color interpolator between two
// requesters; a tag pipeline routes each result back to its owner.
module color_interpolator_arbiter #(
    parameter  int SUB_PIXEL_WIDTH = 8,
    parameter  int IP_LATENCY      = 2,
    localparam int PIXEL_WIDTH     = 4 * SUB_PIXEL_WIDTH
) (
    input  logic                   aclk,
    input  logic                   reset,

    input  logic                   s0_valid,
    output logic                   s0_ready,
    input  logic [15:0]            s0_intensity,
    input  logic [PIXEL_WIDTH-1:0] s0_colorA,
    input  logic [PIXEL_WIDTH-1:0] s0_colorB,

    input  logic                   s1_valid,
    output logic                   s1_ready,
    input  logic [15:0]            s1_intensity,
    input  logic [PIXEL_WIDTH-1:0] s1_colorA,
    input  logic [PIXEL_WIDTH-1:0] s1_colorB,

    output logic                   m0_valid,
    input  logic                   m0_ready,
    output logic [PIXEL_WIDTH-1:0] m0_color,

    output logic                   m1_valid,
    input  logic                   m1_ready,
    output logic [PIXEL_WIDTH-1:0] m1_color,

    output logic                   ip_ce,
    output logic [15:0]            ip_intensity,
    output logic [PIXEL_WIDTH-1:0] ip_colorA,
    output logic [PIXEL_WIDTH-1:0] ip_colorB,
    input  logic [PIXEL_WIDTH-1:0] ip_mixedColor
);

    logic [IP_LATENCY:1] vld_q, vld_d;
    logic [IP_LATENCY:1] tag_q, tag_d;
    logic                rr_ptr_q, rr_ptr_d;

    logic head_vld;
    logic head_tag;
    logic head_ready;
    logic stall;
    logic grant_valid;
    logic grant_id;

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            vld_q    <= '0;
            tag_q    <= '0;
            rr_ptr_q <= 1'b0;
        end else begin
            vld_q    <= vld_d;
            tag_q    <= tag_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // A blocked head freezes the whole pipe, including the interpolator.
    always_comb begin
        head_vld   = vld_q[IP_LATENCY];
        head_tag   = tag_q[IP_LATENCY];
        head_ready = head_tag ? m1_ready : m0_ready;
        stall      = head_vld && !head_ready;
        ip_ce      = !stall;
    end

    always_comb begin
        grant_valid = s0_valid || s1_valid;
        if (s0_valid && s1_valid) begin
            grant_id = rr_ptr_q;
        end else begin
            grant_id = s1_valid;
        end
    end

    always_comb begin
        s0_ready = !stall && !reset && grant_valid && !grant_id;
        s1_ready = !stall && !reset && grant_valid &&  grant_id;
    end

    always_comb begin
        if (grant_valid && grant_id) begin
            ip_intensity = s1_intensity;
            ip_colorA    = s1_colorA;
            ip_colorB    = s1_colorB;
        end else begin
            ip_intensity = s0_intensity;
            ip_colorA    = s0_colorA;
            ip_colorB    = s0_colorB;
        end
    end

    always_comb begin
        vld_d    = vld_q;
        tag_d    = tag_q;
        rr_ptr_d = rr_ptr_q;
        if (ip_ce) begin
            vld_d[1] = grant_valid;
            tag_d[1] = grant_id;
            for (int k = 2; k <= IP_LATENCY; k++) begin
                vld_d[k] = vld_q[k-1];
                tag_d[k] = tag_q[k-1];
            end
            if (grant_valid) begin
                rr_ptr_d = ~grant_id;
            end
        end
    end

    always_comb begin
        m0_valid = head_vld && !head_tag;
        m1_valid = head_vld &&  head_tag;
        m0_color = ip_mixedColor;
        m1_color = ip_mixedColor;
    end

endmodule

// File: tb/tb_color_interpolator_arbiter.sv
// Directed bench for color_interpolator_arbiter with a behavioural
// 2-stage interpolator attached to the ip_* port.
module tb_color_interpolator_arbiter;

    logic        aclk = 1'b0;
    logic        reset;
    logic        s0_valid, s0_ready;
    logic [15:0] s0_intensity;
    logic [31:0] s0_colorA, s0_colorB;
    logic        s1_valid, s1_ready;
    logic [15:0] s1_intensity;
    logic [31:0] s1_colorA, s1_colorB;
    logic        m0_valid, m0_ready;
    logic [31:0] m0_color;
    logic        m1_valid, m1_ready;
    logic [31:0] m1_color;
    logic        ip_ce;
    logic [15:0] ip_intensity;
    logic [31:0] ip_colorA, ip_colorB;
    logic [31:0] ip_mixedColor;

    int passed = 0;
    int total  = 0;

    always #5 aclk = ~aclk;

    color_interpolator_arbiter dut (
        .aclk(aclk), .reset(reset),
        .s0_valid(s0_valid), .s0_ready(s0_ready),
        .s0_intensity(s0_intensity),
        .s0_colorA(s0_colorA), .s0_colorB(s0_colorB),
        .s1_valid(s1_valid), .s1_ready(s1_ready),
        .s1_intensity(s1_intensity),
        .s1_colorA(s1_colorA), .s1_colorB(s1_colorB),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_color(m0_color),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_color(m1_color),
        .ip_ce(ip_ce), .ip_intensity(ip_intensity),
        .ip_colorA(ip_colorA), .ip_colorB(ip_colorB),
        .ip_mixedColor(ip_mixedColor)
    );

    // Interpolator: per-sub-pixel lerp on the top intensity byte.
    function automatic logic [31:0] lerp(input logic [15:0] i16,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
        logic [31:0] r;
        int i;
        int t;
        i = int'(i16[15:8]);
        r = '0;
        for (int s = 0; s < 4; s++) begin
            t = (int'(a[s*8 +: 8]) * i + int'(b[s*8 +: 8]) * (255 - i) + 127) / 255;
            r[s*8 +: 8] = t[7:0];
        end
        return r;
    endfunction

    logic [31:0] p1 = '0;
    logic [31:0] p2 = '0;
    always @(posedge aclk) begin
        if (ip_ce) begin
            p1 <= lerp(ip_intensity, ip_colorA, ip_colorB);
            p2 <= p1;
        end
    end
    assign ip_mixedColor = p2;

    function automatic logic [31:0] rep4(input logic [7:0] v);
        return {4{v}};
    endfunction

    task automatic chk(input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", name, obs, exp);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int n0;
        int n1;
        logic [31:0] ec;
        reset = 1'b1;
        s0_valid = 1'b1; s0_intensity = '0; s0_colorA = '0; s0_colorB = '0;
        s1_valid = 1'b0; s1_intensity = '0; s1_colorA = '0; s1_colorB = '0;
        m0_ready = 1'b1; m1_ready = 1'b1;
        #3;
        chk("rst_s0_ready", 32'(s0_ready), 0);
        chk("rst_m0_valid", 32'(m0_valid), 0);
        chk("rst_m1_valid", 32'(m1_valid), 0);
        chk("rst_ip_ce", 32'(ip_ce), 1);
        s0_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // 1: requester 0 alone
        s0_valid = 1'b1; s0_intensity = 16'hFF00;
        s0_colorA = 32'h11223344; s0_colorB = 32'hAABBCCDD;
        #1;
        chk("t1_s0_ready", 32'(s0_ready), 1);
        chk("t1_s1_ready", 32'(s1_ready), 0);
        chk("t1_ip_int", 32'(ip_intensity), 32'h0000FF00);
        chk("t1_ip_colA", ip_colorA, 32'h11223344);
        tick();
        s0_valid = 1'b0;
        #1;
        chk("t1_m0_early", 32'(m0_valid), 0);
        tick();
        chk("t1_m0_valid", 32'(m0_valid), 1);
        chk("t1_m0_color", m0_color, 32'h11223344);
        chk("t1_m1_valid", 32'(m1_valid), 0);
        tick();
        chk("t1_m0_gone", 32'(m0_valid), 0);

        // 2: requester 1 alone
        s1_valid = 1'b1; s1_intensity = 16'h0000;
        s1_colorA = 32'h11223344; s1_colorB = 32'hAABBCCDD;
        #1;
        chk("t2_s1_ready", 32'(s1_ready), 1);
        chk("t2_s0_ready", 32'(s0_ready), 0);
        tick();
        s1_valid = 1'b0;
        #1;
        chk("t2_m1_early", 32'(m1_valid), 0);
        tick();
        chk("t2_m1_valid", 32'(m1_valid), 1);
        chk("t2_m1_color", m1_color, 32'hAABBCCDD);
        chk("t2_m0_valid", 32'(m0_valid), 0);
        tick();

        // 3: both requesters, alternating grants
        s0_intensity = 16'hFF00; s1_intensity = 16'hFF00;
        s0_colorB = '0; s1_colorB = '0;
        n0 = 0; n1 = 0;
        for (int c = 0; c <= 8; c++) begin
            s0_valid = (c < 8); s1_valid = (c < 8);
            s0_colorA = rep4(8'(c));
            s1_colorA = rep4(8'(8'h80 + c));
            #1;
            if (c < 8) begin
                chk("t3_s0_ready", 32'(s0_ready), 32'((c % 2) == 0));
                chk("t3_s1_ready", 32'(s1_ready), 32'((c % 2) == 1));
            end
            tick();
            if (c >= 1) begin
                chk("t3_m0_valid", 32'(m0_valid), 32'(((c - 1) % 2) == 0));
                chk("t3_m1_valid", 32'(m1_valid), 32'(((c - 1) % 2) == 1));
                if ((c - 1) % 2 == 0) begin
                    ec = rep4(8'(c - 1));
                    chk("t3_m0_color", m0_color, ec);
                end else begin
                    ec = rep4(8'(8'h80 + c - 1));
                    chk("t3_m1_color", m1_color, ec);
                end
                if (m0_valid) n0++;
                if (m1_valid) n1++;
            end
        end
        chk("t3_n0", 32'(n0), 4);
        chk("t3_n1", 32'(n1), 4);
        s0_valid = 1'b0; s1_valid = 1'b0;
        tick();

        // 4: backpressure on requester 0 stalls the pipe
        s0_valid = 1'b1;
        for (int j = 0; j < 2; j++) begin
            s0_colorA = rep4(8'(8'h40 + j));
            #1;
            chk("t4_s0_ready", 32'(s0_ready), 1);
            tick();
        end
        m0_ready = 1'b0;
        s0_colorA = rep4(8'h42);
        for (int j = 0; j < 3; j++) begin
            #1;
            chk("t4_ce_stall", 32'(ip_ce), 0);
            chk("t4_s0_stall", 32'(s0_ready), 0);
            chk("t4_s1_stall", 32'(s1_ready), 0);
            chk("t4_m0_hold", 32'(m0_valid), 1);
            chk("t4_col_hold", m0_color, rep4(8'h40));
            tick();
        end
        m0_ready = 1'b1;
        #1;
        chk("t4_ce_resume", 32'(ip_ce), 1);
        chk("t4_s0_resume", 32'(s0_ready), 1);
        chk("t4_res0", m0_color, rep4(8'h40));
        tick();
        s0_colorA = rep4(8'h43);
        #1;
        chk("t4_v1", 32'(m0_valid), 1);
        chk("t4_res1", m0_color, rep4(8'h41));
        chk("t4_s0_acc3", 32'(s0_ready), 1);
        tick();
        s0_valid = 1'b0;
        #1;
        chk("t4_v2", 32'(m0_valid), 1);
        chk("t4_res2", m0_color, rep4(8'h42));
        tick();
        chk("t4_v3", 32'(m0_valid), 1);
        chk("t4_res3", m0_color, rep4(8'h43));
        tick();
        chk("t4_drained", 32'(m0_valid), 0);

        // 5: reset with jobs in flight; rr_ptr is 1 beforehand
        s0_valid = 1'b1;
        s0_colorA = rep4(8'h55);
        tick();
        tick();
        s0_valid = 1'b0;
        #1;
        chk("t5_inflight", 32'(m0_valid), 1);
        reset = 1'b1;
        #1;
        chk("t5_rst_m0", 32'(m0_valid), 0);
        chk("t5_rst_ce", 32'(ip_ce), 1);
        tick();
        reset = 1'b0;
        #1;
        chk("t5_post_m0", 32'(m0_valid), 0);
        chk("t5_post_m1", 32'(m1_valid), 0);
        tick();
        chk("t5_stale_m0", 32'(m0_valid), 0);
        s0_valid = 1'b1; s1_valid = 1'b1;
        s0_colorA = rep4(8'h66); s1_colorA = rep4(8'h77);
        #1;
        chk("t5_gnt_s0", 32'(s0_ready), 1);
        chk("t5_gnt_s1", 32'(s1_ready), 0);
        tick();
        s0_valid = 1'b0; s1_valid = 1'b0;
        tick();
        chk("t5_new_m0", 32'(m0_valid), 1);
        chk("t5_new_col", m0_color, rep4(8'h66));
        chk("t5_new_m1", 32'(m1_valid), 0);
        tick();

        // 6: requester 1 streams, then requester 0 joins
        s1_valid = 1'b1;
        for (int j = 0; j < 5; j++) begin
            #1;
            chk("t6_s1_alone", 32'(s1_ready), 1);
            tick();
        end
        s0_valid = 1'b1;
        #1;
        chk("t6_first_s0", 32'(s0_ready), 1);
        chk("t6_first_s1", 32'(s1_ready), 0);
        tick();
        chk("t6_alt_s1", 32'(s1_ready), 1);
        chk("t6_alt_s0", 32'(s0_ready), 0);
        tick();
        chk("t6_alt2_s0", 32'(s0_ready), 1);
        s0_valid = 1'b0; s1_valid = 1'b0;
        tick();
        tick();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
